// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// a synchronous flush that inserts a bubble, and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a payload moves upstream->here when in_valid && in_ready, and
    // here->downstream when out_valid && out_ready, both sampled on the rising edge.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops any same-cycle accept; a same-cycle out-transfer already happened downstream.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // out_valid doubles as the main valid bit and !in_ready as the skid valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            if (load_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bubbles carry all-zero control so no write or branch can fire from them.
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, corner sequences and random
// traffic, all checked against a 2-deep FIFO reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W = 69;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 4;
    localparam int PW     = DATA_W + CTRL_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              stat_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        dbg_state;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stat_clr(stat_clr), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: payloads held by the stage, oldest first, packed {ctrl, data}
    logic [PW-1:0]     exp_q[$];
    int                m_cnt;
    logic [DATA_W-1:0] m_last;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_last = '0;
    endtask

    task automatic model_edge(input bit iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                              input bit ordy, input bit fl, input bit clr);
        bit acc;
        bit pop;
        acc = iv && (exp_q.size() < 2);
        pop = (exp_q.size() > 0) && ordy;
        if (clr) m_cnt = 0;
        else if ((exp_q.size() > 0) && !ordy && (m_cnt < CMAX)) m_cnt++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({c, d});
        end
        if (exp_q.size() > 0) m_last = exp_q[0][DATA_W-1:0];
    endtask

    task automatic check_model(input string tag);
        logic [PW-1:0] head;
        chk({tag, "_out_valid"}, 80'(out_valid), 80'(exp_q.size() > 0));
        chk({tag, "_in_ready"},  80'(in_ready),  80'(exp_q.size() < 2));
        chk({tag, "_stall_cnt"}, 80'(stall_cnt), 80'(m_cnt));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk({tag, "_out_data"}, 80'(out_data), 80'(head[DATA_W-1:0]));
            chk({tag, "_out_ctrl"}, 80'(out_ctrl), 80'(head[PW-1:DATA_W]));
        end else begin
            chk({tag, "_out_data"}, 80'(out_data), 80'(m_last));
            chk({tag, "_out_ctrl"}, 80'(out_ctrl), 80'(0));
        end
    endtask

    // driver: called at a falling edge; drives, clocks, updates model, checks at next falling edge
    task automatic apply(input string tag, input bit iv, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input bit ordy, input bit fl, input bit clr);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        stat_clr  = clr;
        @(posedge clk);
        model_edge(iv, d, c, ordy, fl, clr);
        @(negedge clk);
        check_model(tag);
    endtask

    typedef struct {
        bit                iv;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        bit                ordy;
        bit                fl;
        bit                eov;
        logic [DATA_W-1:0] eod;
        logic [CTRL_W-1:0] eoc;
        bit                eir;
        int                ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit iv, input int d, input int c, input bit ordy, input bit fl,
                       input bit eov, input int eod, input int eoc, input bit eir, input int ecnt);
        vec_t v;
        v.iv = iv; v.d = DATA_W'(d); v.c = CTRL_W'(c); v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eod = DATA_W'(eod); v.eoc = CTRL_W'(eoc); v.eir = eir; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    initial begin
        logic [95:0] r;
        model_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(77); in_ctrl = '1;
        out_ready = 1'b0; flush = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 80'(out_valid), 80'(0));
        chk("reset_in_ready",  80'(in_ready),  80'(1));
        chk("reset_out_data",  80'(out_data),  80'(0));
        chk("reset_out_ctrl",  80'(out_ctrl),  80'(0));
        chk("reset_stall_cnt", 80'(stall_cnt), 80'(0));
        rst_n = 1'b1;
        in_valid = 1'b0;

        //   iv  d   c  rdy fl | ov  od  oc  ir cnt
        add(1,  1,  1, 1, 0,   1,  1,  1, 1, 0);   // stream
        add(1,  2,  2, 1, 0,   1,  2,  2, 1, 0);
        add(1,  3,  3, 1, 0,   1,  3,  3, 1, 0);
        add(1,  4,  4, 1, 0,   1,  4,  4, 1, 0);
        add(1, 10,  5, 1, 0,   1, 10,  5, 1, 0);   // A reaches outputs
        add(1, 11,  6, 0, 0,   1, 10,  5, 0, 1);   // B into skid
        add(1, 12,  7, 0, 0,   1, 10,  5, 0, 2);   // C held upstream
        add(1, 12,  7, 1, 0,   1, 11,  6, 1, 2);   // release: B
        add(1, 12,  7, 1, 0,   1, 12,  7, 1, 2);   // C
        add(0,  0,  0, 1, 0,   0, 12,  0, 1, 2);   // drained
        add(1, 20,  1, 0, 0,   1, 20,  1, 1, 2);   // fill for flush
        add(1, 21,  2, 0, 0,   1, 20,  1, 0, 3);
        add(1, 99,  3, 0, 1,   0, 20,  0, 1, 4);   // flush, X dropped
        add(0,  0,  0, 0, 0,   0, 20,  0, 1, 4);
        add(1, 30, 31, 1, 0,   1, 30, 31, 1, 4);   // bubble control
        add(0,  0, 31, 1, 0,   0, 30,  0, 1, 4);
        add(0,  0, 31, 0, 0,   0, 30,  0, 1, 4);

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl, 1'b0);
            chk($sformatf("vec%0d_ov", i),  80'(out_valid), 80'(tbl[i].eov));
            chk($sformatf("vec%0d_od", i),  80'(out_data),  80'(tbl[i].eod));
            chk($sformatf("vec%0d_oc", i),  80'(out_ctrl),  80'(tbl[i].eoc));
            chk($sformatf("vec%0d_ir", i),  80'(in_ready),  80'(tbl[i].eir));
            chk($sformatf("vec%0d_cnt", i), 80'(stall_cnt), 80'(tbl[i].ecnt));
        end

        // saturation: clear, then 20 stalled cycles
        apply("sat_clr", 1'b1, DATA_W'(40), CTRL_W'(1), 1'b0, 1'b0, 1'b1);
        chk("sat_clr_zero", 80'(stall_cnt), 80'(0));
        for (int i = 0; i < 20; i++) apply("sat", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat_value", 80'(stall_cnt), 80'(15));
        apply("stall_clr", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("stall_clr_zero", 80'(stall_cnt), 80'(0));
        apply("stall_resume", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall_resume_one", 80'(stall_cnt), 80'(1));

        // async reset while FULL, between edges
        apply("pre_rst_full", 1'b1, DATA_W'(41), CTRL_W'(2), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_in_ready", 80'(in_ready), 80'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 80'(out_valid), 80'(0));
        chk("arst_in_ready",  80'(in_ready),  80'(1));
        chk("arst_stall_cnt", 80'(stall_cnt), 80'(0));
        chk("arst_out_ctrl",  80'(out_ctrl),  80'(0));
        model_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arst_held_out_valid", 80'(out_valid), 80'(0));
        rst_n = 1'b1;
        apply("post_rst", 1'b1, DATA_W'(50), CTRL_W'(3), 1'b1, 1'b0, 1'b0);
        chk("post_rst_data", 80'(out_data), 80'(50));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [DATA_W-1:0] d;
            r = {$urandom, $urandom, $urandom};
            d = r[DATA_W-1:0];
            apply("rand", $urandom_range(0, 3) != 0, d, CTRL_W'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
